// File: rtl/countdown_timer_if.sv
// Register-access bus between the store bridge and the countdown timer.
// The master drives word address, write strobe and data; the slave returns read data and irq.
interface countdown_timer_if;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;

    modport master (
        output addr,
        output we,
        output din,
        input  dout,
        input  irq
    );

    modport slave (
        input  addr,
        input  we,
        input  din,
        output dout,
        output irq
    );
endinterface

// File: rtl/countdown_timer.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and one-shot or
// auto-reload operation; raises irq when the count expires.
module countdown_timer #(
    parameter logic [31:0] PRESET_RESET = 32'd0
) (
    input  logic              clk,
    input  logic              reset,
    countdown_timer_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StLoad, StCnt, StInt} state_t;

    localparam logic [1:0] AddrCtrl   = 2'd0;
    localparam logic [1:0] AddrPreset = 2'd1;
    localparam logic [1:0] AddrCount  = 2'd2;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic en;
    logic auto_reload;

    assign en          = ctrl_q[0];
    // Reserved MODE encodings fall back to one-shot.
    assign auto_reload = (ctrl_q[2:1] == 2'b01);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!en) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = StInt;
                end
            end
            StInt: begin
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // CPU writes are applied last so they win over same-cycle FSM updates.
        if (bus.we) begin
            if (bus.addr == AddrCtrl) begin
                ctrl_d     = bus.din[3:0];
                irq_flag_d = 1'b0;
            end else if (bus.addr == AddrPreset) begin
                preset_d   = bus.din;
                irq_flag_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ctrl_q     <= 4'd0;
            preset_q   <= PRESET_RESET;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        bus.dout = 32'd0;
        case (bus.addr)
            AddrCtrl:   bus.dout = {28'd0, ctrl_q};
            AddrPreset: bus.dout = preset_q;
            AddrCount:  bus.dout = count_q;
            default:    bus.dout = 32'd0;
        endcase
    end

    assign bus.irq = irq_flag_q & ctrl_q[3];

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random traffic,
// all compared against a timeline-based reference model.
module tb_countdown_timer;

    localparam logic [31:0] PRESET_RESET = 32'd17;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    countdown_timer_if bus ();

    countdown_timer #(.PRESET_RESET(PRESET_RESET)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a run is a timeline indexed by m_t (edges since the enable was seen).
    // t=0 enable seen, t=1 load, t=2..n count down, t=n+1 expiry, t=n+2 wrap-up; -1 = idle.
    bit          m_en, m_im, m_flag;
    bit [1:0]    m_mode;
    bit [31:0]   m_preset, m_count, m_prun;
    longint      m_n;
    int          m_t;

    function automatic bit [31:0] m_read(input bit [1:0] a);
        case (a)
            2'd0:    return {28'd0, m_im, m_mode, m_en};
            2'd1:    return m_preset;
            2'd2:    return m_count;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit m_irq();
        return m_flag & m_im;
    endfunction

    function automatic void model_edge(input bit r, input bit w, input bit [1:0] a,
                                       input bit [31:0] d);
        int nt;
        bit set_flag = 0, clr_flag = 0, clr_en = 0;
        if (r) begin
            m_en = 0; m_im = 0; m_mode = 0; m_flag = 0;
            m_preset = PRESET_RESET; m_count = 0; m_t = -1;
            return;
        end
        if (m_t < 0) begin
            nt = m_en ? 0 : -1;
        end else if (m_t == 0) begin
            m_prun  = m_preset;
            m_n     = (m_preset == 0) ? 1 : longint'(m_preset);
            m_count = m_preset;
            nt      = 1;
        end else if (m_t <= m_n) begin
            if (!m_en) begin
                nt = -1;
            end else begin
                nt = m_t + 1;
                if (nt <= m_n) m_count = m_prun - 32'(m_t);
                else begin
                    m_count  = 0;
                    set_flag = 1;
                end
            end
        end else begin
            if (m_mode == 2'b01) clr_flag = 1;
            else clr_en = 1;
            nt = -1;
        end
        if (set_flag) m_flag = 1;
        if (clr_flag) m_flag = 0;
        if (clr_en) m_en = 0;
        if (w && a == 2'd0) begin
            m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0;
        end else if (w && a == 2'd1) begin
            m_preset = d; m_flag = 0;
        end
        m_t = nt;
    endfunction

    // One clock edge with the given inputs; returns at the following negedge reading COUNT.
    task automatic step(input bit r, input bit w, input bit [1:0] a, input bit [31:0] d);
        reset    = r;
        bus.we   = w;
        bus.addr = a;
        bus.din  = d;
        @(posedge clk);
        model_edge(r, w, a, d);
        @(negedge clk);
        reset    = 1'b0;
        bus.we   = 1'b0;
        bus.addr = 2'd2;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        bus.addr = 2'd0; #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %0h expected 0", bus.dout);
        end
        bus.addr = 2'd1; #1;
        n_checks++;
        if (bus.dout !== PRESET_RESET) begin
            n_fail++; $display("FAIL reset_preset: got %0h expected %0h", bus.dout, PRESET_RESET);
        end
        bus.addr = 2'd2; #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++; $display("FAIL reset_count: got %0h expected 0", bus.dout);
        end
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL reset_irq: got %0b expected 0", bus.irq);
        end
    endtask

    task automatic test_one_shot();
        step(1, 0, 0, 0);
        step(0, 1, 1, 5);
        step(0, 1, 0, 32'h9);
        for (int k = 1; k <= 10; k++) begin
            step(0, 0, 2, 0);
            n_checks += 2;
            if (bus.dout !== m_count) begin
                n_fail++; $display("FAIL oneshot_count[%0d]: got %0d expected %0d", k, bus.dout, m_count);
            end
            if (bus.irq !== (k >= 7)) begin
                n_fail++; $display("FAIL oneshot_irq[%0d]: got %0b expected %0b", k, bus.irq, k >= 7);
            end
            if (k == 2 || k == 6) begin
                n_checks++;
                if (bus.dout !== ((k == 2) ? 32'd5 : 32'd1)) begin
                    n_fail++; $display("FAIL oneshot_sched[%0d]: got %0d", k, bus.dout);
                end
            end
        end
        bus.addr = 2'd0; #1;
        n_checks++;
        if (bus.dout !== 32'h8) begin
            n_fail++; $display("FAIL oneshot_ctrl: got %0h expected 8", bus.dout);
        end
        step(0, 1, 0, 32'h8);
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL oneshot_clear: got %0b expected 0", bus.irq);
        end
    endtask

    task automatic test_auto_reload();
        int last = -1, first = -1, pulses = 0;
        step(1, 0, 0, 0);
        step(0, 1, 1, 3);
        step(0, 1, 0, 32'hB);
        for (int k = 1; k <= 30; k++) begin
            step(0, 0, 2, 0);
            n_checks += 2;
            if (bus.dout !== m_count) begin
                n_fail++; $display("FAIL auto_count[%0d]: got %0d expected %0d", k, bus.dout, m_count);
            end
            if (bus.irq !== m_irq()) begin
                n_fail++; $display("FAIL auto_irq[%0d]: got %0b expected %0b", k, bus.irq, m_irq());
            end
            if (bus.irq === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
                if (last >= 0) begin
                    n_checks++;
                    if (k - last != 6) begin
                        n_fail++; $display("FAIL auto_period: got %0d expected 6", k - last);
                    end
                end
                last = k;
            end
        end
        n_checks += 2;
        if (first != 5) begin
            n_fail++; $display("FAIL auto_first: got %0d expected 5", first);
        end
        if (pulses != 5) begin
            n_fail++; $display("FAIL auto_pulses: got %0d expected 5", pulses);
        end
        bus.addr = 2'd0; #1;
        n_checks++;
        if (bus.dout !== 32'hB) begin
            n_fail++; $display("FAIL auto_ctrl: got %0h expected b", bus.dout);
        end
    endtask

    task automatic test_disable_mid_count();
        bit found = 0;
        step(1, 0, 0, 0);
        step(0, 1, 1, 10);
        step(0, 1, 0, 32'h9);
        for (int k = 0; k < 20 && !found; k++) begin
            step(0, 0, 2, 0);
            if (m_t >= 1 && m_count == 6) found = 1;
        end
        n_checks++;
        if (!found || bus.dout !== 32'd6) begin
            n_fail++; $display("FAIL disable_reach6: got %0d expected 6", bus.dout);
        end
        step(0, 1, 0, 32'h8);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 2, 0);
            n_checks += 2;
            if (bus.dout !== 32'd5 || bus.dout !== m_count) begin
                n_fail++; $display("FAIL disable_frozen[%0d]: got %0d expected 5", k, bus.dout);
            end
            if (bus.irq !== 1'b0) begin
                n_fail++; $display("FAIL disable_irq[%0d]: got %0b expected 0", k, bus.irq);
            end
        end
        step(0, 1, 0, 32'h9);
        step(0, 0, 2, 0);
        step(0, 0, 2, 0);
        n_checks++;
        if (bus.dout !== 32'd10) begin
            n_fail++; $display("FAIL disable_restart: got %0d expected 10", bus.dout);
        end
    endtask

    task automatic test_preset_update();
        step(1, 0, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 32'h9);
        for (int k = 1; k <= 3; k++) step(0, 0, 2, 0);
        n_checks++;
        if (bus.irq !== 1'b1) begin
            n_fail++; $display("FAIL preset0_irq: got %0b expected 1", bus.irq);
        end
        step(0, 1, 0, 32'h0);
        step(0, 0, 2, 0);
        step(0, 1, 1, 4);
        step(0, 1, 0, 32'h9);
        for (int k = 1; k <= 9; k++) begin
            if (k == 3) step(0, 1, 1, 7);
            else step(0, 0, 2, 0);
            n_checks += 2;
            if (bus.irq !== (k >= 6)) begin
                n_fail++; $display("FAIL p4_irq[%0d]: got %0b expected %0b", k, bus.irq, k >= 6);
            end
            if (bus.irq !== m_irq()) begin
                n_fail++; $display("FAIL p4_model[%0d]: got %0b expected %0b", k, bus.irq, m_irq());
            end
        end
        step(0, 1, 0, 32'h9);
        step(0, 0, 2, 0);
        step(0, 0, 2, 0);
        n_checks++;
        if (bus.dout !== 32'd7) begin
            n_fail++; $display("FAIL p7_reload: got %0d expected 7", bus.dout);
        end
    endtask

    task automatic test_masked_and_reset();
        step(1, 0, 0, 0);
        step(0, 1, 1, 2);
        step(0, 1, 0, 32'h1);
        for (int k = 1; k <= 8; k++) begin
            step(0, 0, 2, 0);
            n_checks++;
            if (bus.irq !== 1'b0) begin
                n_fail++; $display("FAIL masked_irq[%0d]: got %0b expected 0", k, bus.irq);
            end
        end
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++; $display("FAIL masked_count: got %0d expected 0", bus.dout);
        end
        step(0, 1, 0, 32'h8);
        n_checks++;
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL masked_unmask: got %0b expected 0", bus.irq);
        end
        step(0, 1, 1, 9);
        step(0, 1, 0, 32'hB);
        for (int k = 0; k < 4; k++) step(0, 0, 2, 0);
        step(1, 0, 2, 0);
        n_checks += 2;
        if (bus.dout !== 32'd0) begin
            n_fail++; $display("FAIL midreset_count: got %0d expected 0", bus.dout);
        end
        if (bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL midreset_irq: got %0b expected 0", bus.irq);
        end
        bus.addr = 2'd0; #1;
        n_checks++;
        if (bus.dout !== 32'd0) begin
            n_fail++; $display("FAIL midreset_ctrl: got %0h expected 0", bus.dout);
        end
        bus.addr = 2'd1; #1;
        n_checks++;
        if (bus.dout !== PRESET_RESET) begin
            n_fail++; $display("FAIL midreset_preset: got %0h expected %0h", bus.dout, PRESET_RESET);
        end
    endtask

    task automatic test_collisions();
        bit found = 0;
        step(1, 0, 0, 0);
        step(0, 1, 1, 2);
        step(0, 1, 0, 32'h9);
        for (int k = 0; k < 10 && !found; k++) begin
            if (m_t >= 1 && m_t == m_n) found = 1;
            else step(0, 0, 2, 0);
        end
        // Write lands on the edge that would set irq_flag.
        step(0, 1, 1, 2);
        n_checks++;
        if (!found || bus.irq !== 1'b0) begin
            n_fail++; $display("FAIL coll_flag: got %0b expected 0", bus.irq);
        end
        // Write lands on the wrap-up edge that would clear EN.
        step(0, 1, 0, 32'h9);
        bus.addr = 2'd0; #1;
        n_checks++;
        if (bus.dout !== 32'h9) begin
            n_fail++; $display("FAIL coll_en: got %0h expected 9", bus.dout);
        end
        for (int k = 1; k <= 6; k++) begin
            step(0, 0, 2, 0);
            n_checks++;
            if (bus.dout !== m_count) begin
                n_fail++; $display("FAIL coll_count[%0d]: got %0d expected %0d", k, bus.dout, m_count);
            end
        end
    endtask

    task automatic test_random();
        bit          r, w;
        bit [1:0]    a, ra;
        bit [31:0]   d;
        step(1, 0, 0, 0);
        for (int k = 0; k < 600; k++) begin
            r = ($urandom_range(0, 149) == 0);
            w = ($urandom_range(0, 5) == 0);
            a = 2'($urandom_range(0, 3));
            if (a == 2'd1) d = $urandom_range(0, 6);
            else if (a == 2'd0) d = {$urandom_range(0, 32'h0FFF_FFFF), 4'($urandom_range(0, 15))};
            else d = $urandom;
            step(r, w, a, d);
            ra = 2'($urandom_range(0, 3));
            bus.addr = ra; #1;
            n_checks += 2;
            if (bus.dout !== m_read(ra)) begin
                n_fail++; $display("FAIL rand_dout[%0d] addr %0d: got %0h expected %0h", k, ra, bus.dout, m_read(ra));
            end
            if (bus.irq !== m_irq()) begin
                n_fail++; $display("FAIL rand_irq[%0d]: got %0b expected %0b", k, bus.irq, m_irq());
            end
        end
    endtask

    initial begin
        reset    = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 2'd0;
        bus.din  = 32'd0;
        @(negedge clk);
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_disable_mid_count();
        test_preset_update();
        test_masked_and_reset();
        test_collisions();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
